// File: rtl/axis_adder_pkg.sv
// Shared types and arithmetic helpers for the N-channel AXI4-Stream adder.
package axis_adder_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_GROW = 2'd2
  } adder_mode_e;

  function automatic int f_out_width(adder_mode_e mode, int nch, int w);
    return (mode == MODE_GROW) ? w + $clog2(nch) : w;
  endfunction

  // Clamp a wide two's-complement sum into the signed range of a w-bit word.
  function automatic logic signed [63:0] f_sat_signed(logic signed [63:0] sum, int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: main register drives the output, skid catches one beat on stall.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
);

  logic [WIDTH-1:0] main_p2;
  logic [WIDTH-1:0] skid_p2;
  logic             vld_p2;
  logic             skid_empty;
  logic             up_fire;

  assign up_ready = skid_empty;
  assign up_fire  = up_valid && skid_empty;
  assign dn_data  = main_p2;
  assign dn_valid = vld_p2;

  // Stage S2: main/skid registers; up_ready comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p2    <= '0;
      skid_p2    <= '0;
      vld_p2     <= 1'b0;
      skid_empty <= 1'b1;
    end else if (!vld_p2 || dn_ready) begin
      if (!skid_empty) begin
        main_p2    <= skid_p2;
        vld_p2     <= 1'b1;
        skid_empty <= 1'b1;
      end else begin
        vld_p2 <= up_fire;
        if (up_fire) main_p2 <= up_data;
      end
    end else if (up_fire) begin
      skid_p2    <= up_data;
      skid_empty <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_adder_nch_pipe.sv
// N-channel AXI4-Stream adder: joins all inputs beat-by-beat, sums, registers and skid-buffers the result.
module axis_adder_nch_pipe
  import axis_adder_pkg::*;
#(
  parameter int          PAR_NCH        = 4,
  parameter int          PAR_WDATA_BYTE = 2,
  parameter adder_mode_e PAR_MODE       = MODE_WRAP,
  localparam int         W              = 8 * PAR_WDATA_BYTE,
  localparam int         WO             = f_out_width(PAR_MODE, PAR_NCH, W)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [PAR_NCH-1:0][W-1:0]   s_axis_tdata,
  input  logic [PAR_NCH-1:0]          s_axis_tvalid,
  input  logic [PAR_NCH-1:0]          s_axis_tlast,
  output logic [PAR_NCH-1:0]          s_axis_tready,
  output logic [WO-1:0]               m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        err_tlast
);

  localparam int WS = W + $clog2(PAR_NCH);

  logic                 all_valid;
  logic                 s1_ready;
  logic                 skid_in_ready;
  logic                 accept;
  logic                 last_or;
  logic                 last_mix;
  logic signed [WS-1:0] ext_p0;
  logic signed [WS-1:0] sum_p0;
  logic signed [63:0]   sat_p0;
  logic [WO-1:0]        red_p0;
  logic [WO-1:0]        sum_p1;
  logic                 last_p1;
  logic                 vld_p1;
  logic [WO:0]          dn_data;
  logic                 unused_bits;

  assign all_valid     = &s_axis_tvalid;
  assign s1_ready      = !vld_p1 || skid_in_ready;
  assign accept        = aresetn && all_valid && s1_ready;
  assign s_axis_tready = {PAR_NCH{accept}};
  assign last_or       = |s_axis_tlast;
  assign last_mix      = last_or && !(&s_axis_tlast);

  // Stage P0: adder tree at full growth width, then mode-dependent reduction
  always_comb begin
    sum_p0 = '0;
    ext_p0 = '0;
    for (int i = 0; i < PAR_NCH; i++) begin
      if (PAR_MODE == MODE_SAT)
        ext_p0 = {{(WS-W){s_axis_tdata[i][W-1]}}, s_axis_tdata[i]};
      else
        ext_p0 = {{(WS-W){1'b0}}, s_axis_tdata[i]};
      sum_p0 = sum_p0 + ext_p0;
    end
    sat_p0 = f_sat_signed({{(64-WS){sum_p0[WS-1]}}, sum_p0}, W);
    if (PAR_MODE == MODE_SAT) red_p0 = sat_p0[WO-1:0];
    else                      red_p0 = sum_p0[WO-1:0];
  end

  // Bits above the chosen output width are intentionally discarded.
  assign unused_bits = ^{sat_p0, sum_p0, ext_p0};

  // Stage P1: sum register, advances whenever the skid buffer can take its content
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1    <= 1'b0;
      sum_p1    <= '0;
      last_p1   <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      if (s1_ready) begin
        vld_p1 <= all_valid;
        if (all_valid) begin
          sum_p1  <= red_p0;
          last_p1 <= last_or;
        end
      end
      if (accept && last_mix) err_tlast <= 1'b1;
    end
  end

  // Stage P2: output skid buffer decouples tready from m_axis_tready
  axis_skid_buf #(
    .WIDTH(WO + 1)
  ) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .up_data  ({sum_p1, last_p1}),
    .up_valid (vld_p1),
    .up_ready (skid_in_ready),
    .dn_data  (dn_data),
    .dn_valid (m_axis_tvalid),
    .dn_ready (m_axis_tready)
  );

  assign m_axis_tdata = dn_data[WO:1];
  assign m_axis_tlast = dn_data[0];

endmodule
